// File: rtl/ipg_tx_arbiter_if.sv
// IPG transmit-slot arbiter bus: requester block streams in, one IPG block stream out.
interface ipg_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ID_W    = 3
);
    logic [NUM_REQ*64-1:0] req_data;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_last;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  slot_avail;
    logic [63:0]           tx_ipg_data;
    logic                  tx_ipg_valid;
    logic [5:0]            tx_len;
    logic [ID_W-1:0]       grant_id;
    logic                  busy;
    logic                  abort_pulse;

    // Arbiter side
    modport master (
        input  req_data, req_valid, req_last, slot_avail,
        output req_ready, tx_ipg_data, tx_ipg_valid, tx_len, grant_id, busy, abort_pulse
    );

    // Requester / PCS side
    modport slave (
        output req_data, req_valid, req_last, slot_avail,
        input  req_ready, tx_ipg_data, tx_ipg_valid, tx_len, grant_id, busy, abort_pulse
    );
endinterface

// File: rtl/ipg_tx_arbiter.sv
// Round-robin arbiter sharing the IPG transmit slot between NUM_REQ message sources.
// A grant is held for a whole message; a stalled grantee is pre-empted with an abort block.
module ipg_tx_arbiter #(
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned STALL_LIMIT = 16,
    parameter int unsigned ID_W        = 3
) (
    input  logic              clk,
    input  logic              reset,
    ipg_tx_arbiter_if.master  bus
);

    localparam int unsigned      BLK_W      = 64;
    localparam int unsigned      CNT_W      = 8;
    localparam int unsigned      LEN_W      = 6;
    localparam logic [LEN_W-1:0] TX_LEN_BLK = LEN_W'(56);
    localparam logic [7:0]       ABORT_TYPE = 8'h3b;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SEND  = 2'd1;
    localparam logic [1:0] S_ABORT = 2'd2;

    logic [1:0]         r_state,       w_state;
    logic [ID_W-1:0]    r_grant_id,    w_grant_id;
    logic [ID_W-1:0]    r_last_grant,  w_last_grant;
    logic [CNT_W-1:0]   r_stall_cnt,   w_stall_cnt;
    logic [BLK_W-1:0]   r_tx_data,     w_tx_data;
    logic               r_tx_valid,    w_tx_valid;
    logic [LEN_W-1:0]   r_tx_len,      w_tx_len;
    logic               r_abort_pulse, w_abort_pulse;

    logic [NUM_REQ-1:0] w_ready;
    logic               w_hi_found, w_lo_found;
    logic [ID_W-1:0]    w_hi_sel, w_lo_sel, w_rr_sel;
    logic               w_g_valid, w_g_last, w_accept;
    logic [BLK_W-1:0]   w_g_data;

    // Round-robin pick: first valid above last_grant, else first valid from 0
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_sel   = '0;
        w_lo_sel   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (bus.req_valid[i] && !w_hi_found && (ID_W'(i) > r_last_grant)) begin
                w_hi_found = 1'b1;
                w_hi_sel   = ID_W'(i);
            end
            if (bus.req_valid[i] && !w_lo_found) begin
                w_lo_found = 1'b1;
                w_lo_sel   = ID_W'(i);
            end
        end
        w_rr_sel = w_hi_found ? w_hi_sel : w_lo_sel;
    end

    // Select the granted requester's valid/last/data
    always_comb begin
        w_g_valid = 1'b0;
        w_g_last  = 1'b0;
        w_g_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == ID_W'(i)) begin
                w_g_valid = bus.req_valid[i];
                w_g_last  = bus.req_last[i];
                w_g_data  = bus.req_data[BLK_W*i +: BLK_W];
            end
        end
    end

    // Next-state, ready and output-register logic
    always_comb begin
        w_state       = r_state;
        w_grant_id    = r_grant_id;
        w_last_grant  = r_last_grant;
        w_stall_cnt   = r_stall_cnt;
        w_tx_data     = r_tx_data;
        w_tx_valid    = 1'b0;
        w_abort_pulse = 1'b0;
        w_ready       = '0;
        w_accept      = w_g_valid && bus.slot_avail;

        case (r_state)
            S_IDLE: begin
                if (|bus.req_valid) begin
                    w_grant_id  = w_rr_sel;
                    w_stall_cnt = '0;
                    w_state     = S_SEND;
                end
            end
            S_SEND: begin
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (r_grant_id == ID_W'(i)) begin
                        w_ready[i] = bus.slot_avail;
                    end
                end
                // Accept takes priority over the stall limit
                if (w_accept) begin
                    w_tx_data   = w_g_data;
                    w_tx_valid  = 1'b1;
                    w_stall_cnt = '0;
                    if (w_g_last) begin
                        w_last_grant = r_grant_id;
                        w_state      = S_IDLE;
                    end
                end else if (bus.slot_avail) begin
                    if ((r_stall_cnt + CNT_W'(1)) == CNT_W'(STALL_LIMIT)) begin
                        w_state = S_ABORT;
                    end else begin
                        w_stall_cnt = r_stall_cnt + CNT_W'(1);
                    end
                end
            end
            S_ABORT: begin
                if (bus.slot_avail) begin
                    w_tx_data     = {48'h0, 5'b0, 3'(r_grant_id), ABORT_TYPE};
                    w_tx_valid    = 1'b1;
                    w_abort_pulse = 1'b1;
                    w_last_grant  = r_grant_id;
                    w_state       = S_IDLE;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_tx_len = w_tx_valid ? TX_LEN_BLK : '0;
    end

    // State and output registers; reset drops any partial message silently
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_grant_id    <= '0;
            r_last_grant  <= ID_W'(NUM_REQ - 1);
            r_stall_cnt   <= '0;
            r_tx_data     <= '0;
            r_tx_valid    <= 1'b0;
            r_tx_len      <= '0;
            r_abort_pulse <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_grant_id    <= w_grant_id;
            r_last_grant  <= w_last_grant;
            r_stall_cnt   <= w_stall_cnt;
            r_tx_data     <= w_tx_data;
            r_tx_valid    <= w_tx_valid;
            r_tx_len      <= w_tx_len;
            r_abort_pulse <= w_abort_pulse;
        end
    end

    assign bus.req_ready    = w_ready;
    assign bus.tx_ipg_data  = r_tx_data;
    assign bus.tx_ipg_valid = r_tx_valid;
    assign bus.tx_len       = r_tx_len;
    assign bus.grant_id     = r_grant_id;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.abort_pulse  = r_abort_pulse;

endmodule

// File: tb/tb_ipg_tx_arbiter.sv
// Directed self-checking bench for ipg_tx_arbiter (3 requesters, stall limit 4).
module tb_ipg_tx_arbiter;

    localparam int unsigned NUM_REQ     = 3;
    localparam int unsigned STALL_LIMIT = 4;
    localparam int unsigned ID_W        = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    ipg_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    ipg_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .STALL_LIMIT (STALL_LIMIT),
        .ID_W        (ID_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [63:0] data;
        logic        abrt;
        logic        vld;
        logic [5:0]  len;
    } ent_t;

    // Requester queues: {last, data}
    logic [64:0] q0[$];
    logic [64:0] q1[$];
    logic [64:0] q2[$];
    logic [2:0]  hold;
    ent_t        log_q[$];
    int          cyc;
    int          c0;
    int          n_chk;
    int          n_fail;

    logic [2:0]   drv_v, drv_l, drv_acc;
    logic [191:0] drv_d;
    logic [64:0]  drv_h;
    ent_t         mon_e;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Pop the next logged output block and compare against expectation
    task automatic exp_blk(input string tag, input int rel, input logic [63:0] d, input logic ab);
        ent_t e;
        if (log_q.size() == 0) begin
            chk({tag, "_present"}, 64'(log_q.size()), 64'(1));
            return;
        end
        e = log_q.pop_front();
        chk({tag, "_cyc"},   64'(e.cyc - c0), 64'(rel));
        chk({tag, "_data"},  e.data, d);
        chk({tag, "_valid"}, 64'(e.vld), 64'(1));
        chk({tag, "_abort"}, 64'(e.abrt), 64'(ab));
        chk({tag, "_len"},   64'(e.len), 64'(56));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q0.delete();
        q1.delete();
        q2.delete();
        hold = '0;
        @(negedge clk);
        reset = 1'b0;
        log_q.delete();
    endtask

    // Requester driver: present queue heads, pop on handshake
    initial begin
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        forever begin
            @(negedge clk);
            #1;
            drv_v = '0;
            drv_l = '0;
            drv_d = '0;
            if (q0.size() > 0) begin
                drv_h = q0[0]; drv_d[63:0] = drv_h[63:0]; drv_l[0] = drv_h[64]; drv_v[0] = !hold[0];
            end
            if (q1.size() > 0) begin
                drv_h = q1[0]; drv_d[127:64] = drv_h[63:0]; drv_l[1] = drv_h[64]; drv_v[1] = !hold[1];
            end
            if (q2.size() > 0) begin
                drv_h = q2[0]; drv_d[191:128] = drv_h[63:0]; drv_l[2] = drv_h[64]; drv_v[2] = !hold[2];
            end
            bus.req_valid = drv_v;
            bus.req_last  = drv_l;
            bus.req_data  = drv_d;
            #3;
            drv_acc = bus.req_valid & bus.req_ready & {3{~reset}};
            @(posedge clk);
            if (drv_acc[0]) void'(q0.pop_front());
            if (drv_acc[1]) void'(q1.pop_front());
            if (drv_acc[2]) void'(q2.pop_front());
        end
    end

    // Output monitor: log every valid or abort cycle with its edge number
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.tx_ipg_valid || bus.abort_pulse) begin
                mon_e.cyc  = cyc;
                mon_e.data = bus.tx_ipg_data;
                mon_e.abrt = bus.abort_pulse;
                mon_e.vld  = bus.tx_ipg_valid;
                mon_e.len  = bus.tx_len;
                log_q.push_back(mon_e);
            end
        end
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        hold   = '0;
        bus.slot_avail = 1'b1;
        reset  = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_valid", 64'(bus.tx_ipg_valid), 64'(0));
        chk("rst_data",  bus.tx_ipg_data, 64'(0));
        chk("rst_len",   64'(bus.tx_len), 64'(0));
        chk("rst_grant", 64'(bus.grant_id), 64'(0));
        chk("rst_busy",  64'(bus.busy), 64'(0));
        chk("rst_abort", 64'(bus.abort_pulse), 64'(0));
        chk("rst_ready", 64'(bus.req_ready), 64'(0));

        // Single 3-block message from requester 1
        reset = 1'b0;
        log_q.delete();
        q1.push_back({1'b0, 64'hA1A1_0000_0000_002b});
        q1.push_back({1'b0, 64'hA1A1_0000_0000_001b});
        q1.push_back({1'b1, 64'hA1A1_0000_0000_000b});
        c0 = cyc;
        @(negedge clk); #2;
        chk("a_grant", 64'(bus.grant_id), 64'(1));
        chk("a_busy",  64'(bus.busy), 64'(1));
        chk("a_ready", 64'(bus.req_ready), 64'(2));
        repeat (3) @(negedge clk);
        chk("a_busy_end", 64'(bus.busy), 64'(0));
        @(negedge clk);
        chk("a_hold_data", bus.tx_ipg_data, 64'hA1A1_0000_0000_000b);
        chk("a_idle_valid", 64'(bus.tx_ipg_valid), 64'(0));
        chk("a_idle_len", 64'(bus.tx_len), 64'(0));
        exp_blk("a0", 2, 64'hA1A1_0000_0000_002b, 1'b0);
        exp_blk("a1", 3, 64'hA1A1_0000_0000_001b, 1'b0);
        exp_blk("a2", 4, 64'hA1A1_0000_0000_000b, 1'b0);
        chk("a_extra", 64'(log_q.size()), 64'(0));

        // Round-robin from reset; requester 0 re-armed with a second message
        do_reset();
        q0.push_back({1'b0, 64'h0000_0000_0000_a000});
        q0.push_back({1'b1, 64'h0000_0000_0000_a001});
        q0.push_back({1'b0, 64'h0000_0000_0000_a002});
        q0.push_back({1'b1, 64'h0000_0000_0000_a003});
        q1.push_back({1'b0, 64'h0000_0000_0000_b000});
        q1.push_back({1'b1, 64'h0000_0000_0000_b001});
        q2.push_back({1'b0, 64'h0000_0000_0000_c000});
        q2.push_back({1'b1, 64'h0000_0000_0000_c001});
        c0 = cyc;
        repeat (13) @(negedge clk);
        exp_blk("b_a0", 2,  64'h0000_0000_0000_a000, 1'b0);
        exp_blk("b_a1", 3,  64'h0000_0000_0000_a001, 1'b0);
        exp_blk("b_b0", 5,  64'h0000_0000_0000_b000, 1'b0);
        exp_blk("b_b1", 6,  64'h0000_0000_0000_b001, 1'b0);
        exp_blk("b_c0", 8,  64'h0000_0000_0000_c000, 1'b0);
        exp_blk("b_c1", 9,  64'h0000_0000_0000_c001, 1'b0);
        exp_blk("b_a2", 11, 64'h0000_0000_0000_a002, 1'b0);
        exp_blk("b_a3", 12, 64'h0000_0000_0000_a003, 1'b0);
        chk("b_extra", 64'(log_q.size()), 64'(0));

        // Slot back-pressure: slot toggles 1,0,1,0 during a 4-block message
        log_q.delete();
        q1.push_back({1'b0, 64'hD0D0_0000_0000_0010});
        q1.push_back({1'b0, 64'hD0D0_0000_0000_0011});
        q1.push_back({1'b0, 64'hD0D0_0000_0000_0012});
        q1.push_back({1'b1, 64'hD0D0_0000_0000_0013});
        c0 = cyc;
        #2;
        chk("c_ready_idle", 64'(bus.req_ready), 64'(0));
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            bus.slot_avail = (k % 2 == 0);
            #2;
            chk("c_ready", 64'(bus.req_ready), (k % 2 == 0) ? 64'(2) : 64'(0));
        end
        @(negedge clk);
        bus.slot_avail = 1'b1;
        chk("c_busy_end", 64'(bus.busy), 64'(0));
        exp_blk("c_d0", 2, 64'hD0D0_0000_0000_0010, 1'b0);
        exp_blk("c_d1", 4, 64'hD0D0_0000_0000_0011, 1'b0);
        exp_blk("c_d2", 6, 64'hD0D0_0000_0000_0012, 1'b0);
        exp_blk("c_d3", 8, 64'hD0D0_0000_0000_0013, 1'b0);
        chk("c_extra", 64'(log_q.size()), 64'(0));

        // Stall abort: requester 2 sends one block then goes quiet
        log_q.delete();
        q2.push_back({1'b0, 64'hE2E2_0000_0000_002b});
        q0.push_back({1'b1, 64'hF0F0_0000_0000_000b});
        c0 = cyc;
        repeat (6) @(negedge clk); #2;
        chk("d_abort_busy",  64'(bus.busy), 64'(1));
        chk("d_abort_ready", 64'(bus.req_ready), 64'(0));
        chk("d_abort_grant", 64'(bus.grant_id), 64'(2));
        @(negedge clk);
        chk("d_pulse", 64'(bus.abort_pulse), 64'(1));
        chk("d_blk",   bus.tx_ipg_data, 64'h0000_0000_0000_023b);
        @(negedge clk);
        chk("d_pulse_low", 64'(bus.abort_pulse), 64'(0));
        chk("d_next_grant", 64'(bus.grant_id), 64'(0));
        @(negedge clk);
        exp_blk("d_e0",  2, 64'hE2E2_0000_0000_002b, 1'b0);
        exp_blk("d_abt", 7, 64'h0000_0000_0000_023b, 1'b1);
        exp_blk("d_f0",  9, 64'hF0F0_0000_0000_000b, 1'b0);
        chk("d_extra", 64'(log_q.size()), 64'(0));

        // Reset after 2 of 4 blocks
        log_q.delete();
        q1.push_back({1'b0, 64'h6060_0000_0000_0000});
        q1.push_back({1'b0, 64'h6060_0000_0000_0001});
        q1.push_back({1'b0, 64'h6060_0000_0000_0002});
        q1.push_back({1'b1, 64'h6060_0000_0000_0003});
        c0 = cyc;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("e_valid", 64'(bus.tx_ipg_valid), 64'(0));
        chk("e_data",  bus.tx_ipg_data, 64'(0));
        chk("e_len",   64'(bus.tx_len), 64'(0));
        chk("e_grant", 64'(bus.grant_id), 64'(0));
        chk("e_busy",  64'(bus.busy), 64'(0));
        chk("e_abort", 64'(bus.abort_pulse), 64'(0));
        chk("e_ready", 64'(bus.req_ready), 64'(0));
        reset = 1'b0;
        q1.delete();
        q1.push_back({1'b1, 64'h6060_0000_0000_00ff});
        q0.push_back({1'b1, 64'h7070_0000_0000_0000});
        @(negedge clk); #2;
        chk("e_first_grant", 64'(bus.grant_id), 64'(0));
        repeat (4) @(negedge clk);
        exp_blk("e_g0",  2, 64'h6060_0000_0000_0000, 1'b0);
        exp_blk("e_g1",  3, 64'h6060_0000_0000_0001, 1'b0);
        exp_blk("e_h0",  6, 64'h7070_0000_0000_0000, 1'b0);
        exp_blk("e_g0r", 8, 64'h6060_0000_0000_00ff, 1'b0);
        chk("e_extra", 64'(log_q.size()), 64'(0));

        // Last block accepted with stall_cnt at STALL_LIMIT-1
        log_q.delete();
        q2.push_back({1'b0, 64'h8B8B_0000_0000_0000});
        q2.push_back({1'b1, 64'h8B8B_0000_0000_0001});
        c0 = cyc;
        repeat (2) @(negedge clk);
        hold = 3'b100;
        repeat (3) @(negedge clk);
        hold = 3'b000;
        @(negedge clk);
        chk("f_valid", 64'(bus.tx_ipg_valid), 64'(1));
        chk("f_abort", 64'(bus.abort_pulse), 64'(0));
        chk("f_busy",  64'(bus.busy), 64'(0));
        repeat (2) @(negedge clk);
        exp_blk("f_k0", 2, 64'h8B8B_0000_0000_0000, 1'b0);
        exp_blk("f_k1", 6, 64'h8B8B_0000_0000_0001, 1'b0);
        chk("f_extra", 64'(log_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
